izh_neuron_sequencer: RTL and testbench
=======================================

Name: izh_neuron_sequencer

Overview:
- Upstream feeder and write-back stage for the izhikevich update core.
- Holds per-neuron parameters (a, b, c, d) and state (v, u) for N neurons in on-chip RAM.
- On each timestep sweeps neurons 0..N-1: presents operands plus synaptic current i to the core, writes v_prime/u_prime back, and queues the IDs of fired neurons in a spike FIFO for the downstream router.

Parameters:
- N_NEURONS, 64, number of neurons swept per timestep
- ID_W, 6, neuron index width (clog2 of N_NEURONS)
- DW, 17, fixed-point word width (sign, 8 integer, 8 fraction), passed through unmodified
- CORE_LAT, 1, cycles from operands valid at the core to v_prime/u_prime/fired valid
- FIFO_DEPTH, 8, spike FIFO entries (power of two)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a timestep sweep
- busy  out  1  high from accepted start until last write-back
- done  out  1  one-cycle pulse after last write-back
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  ID_W  neuron to configure
- cfg_a, cfg_b, cfg_c, cfg_d, cfg_v, cfg_u  in  DW each  values written on cfg_we
- cur_addr  out  ID_W  neuron index sent to the current buffer
- cur_data  in  DW  synaptic current, valid one cycle after cur_addr
- core_a, core_b, core_c, core_d, core_v, core_u, core_i  out  DW each  core operands
- core_v_prime, core_u_prime  in  DW each  core results
- core_fired  in  1  core spike flag
- spike_valid  out  1  FIFO non-empty
- spike_id  out  ID_W  head-of-FIFO neuron ID
- spike_ready  in  1  downstream accepts head when high with spike_valid

Behaviour:
- Reset (async): busy=0, done=0, spike_valid=0, FIFO emptied, issue counter=0, all core_* and cur_addr=0. RAM contents not cleared.
- FSM states:
  - IDLE: on start, enter SWEEP, set busy=1, issue pointer=0.
  - SWEEP: issue one neuron per cycle unless stalled; after issuing N_NEURONS-1, enter DRAIN.
  - DRAIN: wait for in-flight write-backs to complete, then enter DONE.
  - DONE: pulse done for one cycle, clear busy, return to IDLE.
- Pipeline, issue at cycle t for neuron n:
  - t: RAM read address=n, cur_addr=n.
  - t+1: core_* driven from RAM/cur_data (registered).
  - t+1+CORE_LAT: v_prime/u_prime written to RAM[n]; if core_fired, n pushed to FIFO.
- Stall rule: issue only when fifo_count + inflight < FIFO_DEPTH (inflight = issued but not yet written back, at most CORE_LAT+1). The FIFO never overflows and no spike is dropped. In-flight operations always complete.
- FIFO:
  - Pop when spike_valid && spike_ready.
  - Simultaneous push and pop when full or empty behaves correctly: count unchanged when full; when empty, the pushed entry appears the next cycle.
  - Order equals neuron index order within a sweep.
  - FIFO persists across sweeps.
- Config:
  - cfg_we writes all six fields of cfg_addr in IDLE only; ignored while busy.
  - cfg_we and start in the same IDLE cycle: the write is performed and start is ignored.
- start while busy: ignored.
- Reset mid-sweep: sweep aborted, neurons already written back keep new state, others keep old state.
- N_NEURONS=1: single issue, done at cycle 3+CORE_LAT after start.
- Sweep latency with no stalls: done pulses at cycle N_NEURONS+CORE_LAT+2 after the start cycle.

Test Plan:
- Reset then cfg neuron 0 with a=0x00300, b=0x01400, c=0x00300, d=0x00300, v=0x00A00, u=0x0B400; start; cur_data=0x00600 -> core_* show those values one cycle after cur_addr=0; RAM[0] gets core_v_prime/u_prime.
- Full 64-neuron sweep, core model fires on even IDs, spike_ready=1 -> 32 spikes IDs 0,2,...,62 in order; done at cycle 67 (CORE_LAT=1).
- Core fires every neuron, spike_ready=0 -> issue stalls with FIFO at 8 entries and busy=1; releasing spike_ready drains all 64 IDs with no loss or duplication.
- cfg_we with start same cycle -> config stored, busy stays 0; cfg_we during sweep -> RAM unchanged.
- Assert rst mid-sweep at neuron 20 -> busy=0, spike_valid=0 immediately; new sweep reads updated state for neurons 0..~18 and original state for the rest.
- Back-to-back sweeps: second sweep's core_v equals first sweep's v_prime per neuron.

Source files
------------

// File: rtl/izh_neuron_sequencer.sv
// Timestep sequencer for the Izhikevich update core: sweeps every neuron through the core,
// writes v/u back to on-chip RAM and queues fired neuron IDs for the spike router.
module izh_neuron_sequencer #(
   parameter int unsigned N_NEURONS  = 64,
   parameter int unsigned ID_W       = 6,
   parameter int unsigned DW         = 17,
   parameter int unsigned CORE_LAT   = 1,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            busy,
   output logic            done,
   input  logic            cfg_we,
   input  logic [ID_W-1:0] cfg_addr,
   input  logic [DW-1:0]   cfg_a,
   input  logic [DW-1:0]   cfg_b,
   input  logic [DW-1:0]   cfg_c,
   input  logic [DW-1:0]   cfg_d,
   input  logic [DW-1:0]   cfg_v,
   input  logic [DW-1:0]   cfg_u,
   output logic [ID_W-1:0] cur_addr,
   input  logic [DW-1:0]   cur_data,
   output logic [DW-1:0]   core_a,
   output logic [DW-1:0]   core_b,
   output logic [DW-1:0]   core_c,
   output logic [DW-1:0]   core_d,
   output logic [DW-1:0]   core_v,
   output logic [DW-1:0]   core_u,
   output logic [DW-1:0]   core_i,
   input  logic [DW-1:0]   core_v_prime,
   input  logic [DW-1:0]   core_u_prime,
   input  logic            core_fired,
   output logic            spike_valid,
   output logic [ID_W-1:0] spike_id,
   input  logic            spike_ready
);

   localparam int unsigned FW = $clog2(FIFO_DEPTH);
   localparam int unsigned OW = $clog2(FIFO_DEPTH + CORE_LAT + 2) + 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_NEURONS - 1);

   typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] c;
      logic [DW-1:0] d;
      logic [DW-1:0] v;
      logic [DW-1:0] u;
   } ops_t;

   logic [DW-1:0] a_mem [N_NEURONS];
   logic [DW-1:0] b_mem [N_NEURONS];
   logic [DW-1:0] c_mem [N_NEURONS];
   logic [DW-1:0] d_mem [N_NEURONS];
   logic [DW-1:0] v_mem [N_NEURONS];
   logic [DW-1:0] u_mem [N_NEURONS];
   logic [ID_W-1:0] fifo_mem [FIFO_DEPTH];

   state_e          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [CORE_LAT:0] vld_q, vld_d;
   logic [ID_W-1:0] id_q [CORE_LAT+1];
   logic [ID_W-1:0] id_d [CORE_LAT+1];
   ops_t            ops_q, ops_d;
   logic [FW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [FW:0]     cnt_q, cnt_d;

   logic [OW-1:0]   occ;
   logic            issue, cfg_wr, wb, push, pop, do_push;
   logic [ID_W-1:0] wb_id;

   assign wb    = vld_q[CORE_LAT];
   assign wb_id = id_q[CORE_LAT];
   assign push  = wb & core_fired;
   assign pop   = (cnt_q != '0) & spike_ready;
   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_push = push & ((cnt_q != (FW+1)'(FIFO_DEPTH)) | pop);

   always_comb begin
      occ = OW'(cnt_q);
      for (int k = 0; k <= int'(CORE_LAT); k++) begin
         occ = occ + OW'(vld_q[k]);
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      issue   = 1'b0;
      cfg_wr  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_we) begin
               cfg_wr = 1'b1;
            end else if (start) begin
               state_d = StSweep;
               ptr_d   = '0;
            end
         end
         StSweep: begin
            // Reserve a FIFO slot for every operation that could still fire.
            if (occ < OW'(FIFO_DEPTH)) begin
               issue = 1'b1;
               if (ptr_q == LAST_ID) state_d = StDrain;
               else                  ptr_d   = ptr_q + ID_W'(1);
            end
         end
         StDrain: begin
            if (vld_q[CORE_LAT-1:0] == '0) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
            ptr_d   = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      vld_d = {vld_q[CORE_LAT-1:0], issue};
      id_d[0] = ptr_q;
      for (int k = 1; k <= int'(CORE_LAT); k++) begin
         id_d[k] = id_q[k-1];
      end
      ops_d = ops_q;
      if (issue) begin
         ops_d.a = a_mem[ptr_q];
         ops_d.b = b_mem[ptr_q];
         ops_d.c = c_mem[ptr_q];
         ops_d.d = d_mem[ptr_q];
         ops_d.v = v_mem[ptr_q];
         ops_d.u = u_mem[ptr_q];
      end
      wr_ptr_d = wr_ptr_q + FW'(do_push);
      rd_ptr_d = rd_ptr_q + FW'(pop);
      cnt_d    = cnt_q + (FW+1)'(do_push) - (FW+1)'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         vld_q    <= '0;
         for (int k = 0; k <= int'(CORE_LAT); k++) id_q[k] <= '0;
         ops_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         vld_q    <= vld_d;
         for (int k = 0; k <= int'(CORE_LAT); k++) id_q[k] <= id_d[k];
         ops_q    <= ops_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage arrays are not reset; write-back and config never coincide.
   always_ff @(posedge clk) begin
      if (wb) begin
         v_mem[wb_id] <= core_v_prime;
         u_mem[wb_id] <= core_u_prime;
      end else if (cfg_wr) begin
         a_mem[cfg_addr] <= cfg_a;
         b_mem[cfg_addr] <= cfg_b;
         c_mem[cfg_addr] <= cfg_c;
         d_mem[cfg_addr] <= cfg_d;
         v_mem[cfg_addr] <= cfg_v;
         u_mem[cfg_addr] <= cfg_u;
      end
      if (do_push) fifo_mem[wr_ptr_q] <= wb_id;
   end

   assign busy        = (state_q == StSweep) | (state_q == StDrain);
   assign done        = (state_q == StDone);
   assign cur_addr    = ptr_q;
   assign core_a      = ops_q.a;
   assign core_b      = ops_q.b;
   assign core_c      = ops_q.c;
   assign core_d      = ops_q.d;
   assign core_v      = ops_q.v;
   assign core_u      = ops_q.u;
   // Current buffer output is already registered one cycle behind cur_addr.
   assign core_i      = vld_q[0] ? cur_data : '0;
   assign spike_valid = (cnt_q != '0);
   assign spike_id    = fifo_mem[rd_ptr_q];

endmodule

// File: tb/tb_izh_neuron_sequencer.sv
// Scoreboard bench for izh_neuron_sequencer: a stub core and current buffer feed the DUT while a
// neuron-array model predicts operand sets and spike IDs per sweep.
module tb_izh_neuron_sequencer;
   localparam int N = 64, IDW = 6, DW = 17, CL = 1, FD = 8;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_we = 1'b0, spike_ready = 1'b0;
   logic busy, done, spike_valid, core_fired;
   logic [IDW-1:0] cfg_addr = '0, cur_addr, spike_id;
   logic [DW-1:0] cfg_a = '0, cfg_b = '0, cfg_c = '0, cfg_d = '0, cfg_v = '0, cfg_u = '0;
   logic [DW-1:0] cur_data, core_a, core_b, core_c, core_d, core_v, core_u, core_i;
   logic [DW-1:0] core_v_prime, core_u_prime;

   izh_neuron_sequencer #(.N_NEURONS(N), .ID_W(IDW), .DW(DW), .CORE_LAT(CL), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_c(cfg_c),
      .cfg_d(cfg_d), .cfg_v(cfg_v), .cfg_u(cfg_u), .cur_addr(cur_addr), .cur_data(cur_data),
      .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d), .core_v(core_v),
      .core_u(core_u), .core_i(core_i), .core_v_prime(core_v_prime),
      .core_u_prime(core_u_prime), .core_fired(core_fired), .spike_valid(spike_valid),
      .spike_id(spike_id), .spike_ready(spike_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] a, b, c, d, v, u, i;
   } ops_t;

   int n_tests = 0, n_fail = 0, cyc = 0, ops_seen = 0, fire_mode = 0, rdy_mode = 0;
   logic [DW-1:0] cur_tab [N];
   logic [DW-1:0] m_a [N], m_b [N], m_c [N], m_d [N], m_v [N], m_u [N], nv [N], nu [N];
   int seen_cyc [N];
   ops_t exp_ops [$];
   logic [IDW-1:0] exp_spk [$];

   function automatic logic [DW-1:0] f_v(input logic [DW-1:0] v, b, i);
      return v + i + b;
   endfunction
   function automatic logic [DW-1:0] f_u(input logic [DW-1:0] u, a, d);
      return u ^ (a + d);
   endfunction
   function automatic logic f_fire(input int mode, input logic [DW-1:0] a, v, i);
      if (mode == 0) return ~a[0];
      if (mode == 1) return 1'b1;
      return v[3] ^ i[2];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) cur_data <= cur_tab[cur_addr];
   always @(posedge clk) begin
      core_v_prime <= f_v(core_v, core_b, core_i);
      core_u_prime <= f_u(core_u, core_a, core_d);
      core_fired   <= f_fire(fire_mode, core_a, core_v, core_i);
      spike_ready  <= (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   // Operand sets are recognised by a change of core_a; every a carries its neuron ID in the low bits.
   logic [DW-1:0] prev_a = '0;
   always @(negedge clk) begin : monitor
      ops_t got, e;
      if (rst) begin
         prev_a = '0;
      end else begin
         if (core_a != prev_a && core_a != '0) begin
            got = {core_a, core_b, core_c, core_d, core_v, core_u, core_i};
            if (exp_ops.size() == 0) begin
               fail("unexpected_operands");
            end else begin
               e = exp_ops.pop_front();
               check("core_operands", got, e);
               seen_cyc[core_a[IDW-1:0]] = cyc;
               ops_seen++;
            end
         end
         prev_a = core_a;
         if (spike_valid && spike_ready) begin
            if (exp_spk.size() == 0) fail("unexpected_spike");
            else check("spike_id", spike_id, exp_spk.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [IDW-1:0] n, input logic [DW-1:0] a, b, c, d, v, u,
                            input bit with_start, input bit upd);
      cfg_we = 1'b1; start = with_start; cfg_addr = n;
      cfg_a = a; cfg_b = b; cfg_c = c; cfg_d = d; cfg_v = v; cfg_u = u;
      tick(1);
      cfg_we = 1'b0; start = 1'b0;
      if (upd) begin
         m_a[n] = a; m_b[n] = b; m_c[n] = c; m_d[n] = d; m_v[n] = v; m_u[n] = u;
      end
   endtask

   function automatic logic [DW-1:0] tag_a(input int n);
      return DW'(($urandom_range(1, 2047) << IDW) | n);
   endfunction

   task automatic rand_cur();
      for (int n = 0; n < N; n++) cur_tab[n] = DW'($urandom);
   endtask

   task automatic prep(input int mode);
      logic [DW-1:0] i;
      fire_mode = mode;
      ops_seen = 0;
      for (int n = 0; n < N; n++) begin
         i = cur_tab[n];
         exp_ops.push_back({m_a[n], m_b[n], m_c[n], m_d[n], m_v[n], m_u[n], i});
         nv[n] = f_v(m_v[n], m_b[n], i);
         nu[n] = f_u(m_u[n], m_a[n], m_d[n]);
         if (f_fire(mode, m_a[n], m_v[n], i)) exp_spk.push_back(IDW'(n));
         seen_cyc[n] = -1;
      end
   endtask

   task automatic run_sweep(input int mode, input int rmode, input int exp_lat,
                            input bit junk, input bit probe);
      int t0;
      bit got_done;
      prep(mode);
      rdy_mode = rmode;
      start = 1'b1; t0 = cyc;
      tick(1);
      start = 1'b0;
      if (junk) begin
         tick(8);
         cfg_write(IDW'(40), DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                   DW'($urandom), DW'($urandom), 1'b0, 1'b0);
      end
      if (probe) begin
         repeat (40) @(negedge clk);
         check("stall_issued", ops_seen, FD);
         check("stall_busy", busy, 1'b1);
         check("stall_valid", spike_valid, 1'b1);
         check("stall_head", spike_id, 0);
         rdy_mode = 1;
      end
      got_done = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            break;
         end
      end
      if (!got_done) fail("done_timeout");
      else if (exp_lat > 0) check("done_latency", cyc - t0, exp_lat);
      @(negedge clk);
      check("done_pulse_busy", {busy, done}, 2'b00);
      for (int n = 0; n < N; n++) begin
         m_v[n] = nv[n];
         m_u[n] = nu[n];
      end
      for (int k = 0; k < 500 && exp_spk.size() != 0; k++) @(negedge clk);
      check("spikes_left", exp_spk.size(), 0);
      check("operands_left", exp_ops.size(), 0);
      tick(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog");
   end

   initial begin
      bit hit;
      int r;
      #3;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_spike_valid", spike_valid, 1'b0);
      check("rst_cur_addr", cur_addr, 0);
      check("rst_core_ops", {core_a, core_b, core_c, core_d, core_v, core_u, core_i}, 0);
      tick(2);
      rst = 1'b0;
      tick(1);

      cfg_write(IDW'(0), 17'h00300, 17'h01400, 17'h00300, 17'h00300, 17'h00A00, 17'h0B400,
                1'b0, 1'b1);
      for (int n = 1; n < N; n++)
         cfg_write(IDW'(n), tag_a(n), DW'($urandom), DW'($urandom), DW'($urandom),
                   DW'($urandom), DW'($urandom), 1'b0, 1'b1);

      // Directed first sweep: neuron 0 current 0x600, even IDs fire, no backpressure.
      rand_cur();
      cur_tab[0] = 17'h00600;
      run_sweep(0, 1, N + CL + 2, 1'b0, 1'b0);

      // Config beside start: write lands, sweep does not begin.
      cfg_write(IDW'(5), tag_a(5), DW'($urandom), DW'($urandom), DW'($urandom),
                DW'($urandom), DW'($urandom), 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("cfg_start_busy", busy, 1'b0);
      end
      tick(1);

      // Every neuron fires with downstream blocked, then released.
      rand_cur();
      run_sweep(1, 0, 0, 1'b0, 1'b1);

      // Random firing and backpressure, with a config write attempted mid-sweep.
      rand_cur();
      run_sweep(2, 2, 0, 1'b1, 1'b0);

      // Reset while neuron ~20 is being issued.
      rand_cur();
      prep(0);
      rdy_mode = 1;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (ops_seen >= 20) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail("reset_point_timeout");
      @(posedge clk);
      #1 rst = 1'b1;
      r = cyc;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_spike_valid", spike_valid, 1'b0);
      for (int n = 0; n < N; n++) begin
         if (seen_cyc[n] >= 0 && seen_cyc[n] + CL < r) begin
            m_v[n] = nv[n];
            m_u[n] = nu[n];
         end
      end
      exp_ops.delete();
      exp_spk.delete();
      tick(2);
      rst = 1'b0;
      tick(2);

      // Back-to-back sweeps: each reads what the previous one wrote back.
      rand_cur();
      run_sweep(2, 2, 0, 1'b0, 1'b0);
      rand_cur();
      run_sweep(0, 1, N + CL + 2, 1'b0, 1'b0);
      rand_cur();
      run_sweep(2, 1, 0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
